// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the board reset sequencer.
// Watchdog option is selected by RESET_SEQUENCER_WDT_EN.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    POR_WAIT = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    HOLD     = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Counter width for a terminal count of v-1; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side signal bundle of the reset sequencer: button, watchdog kick,
// sequenced resets and status. master = sequencer, slave = board top level.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 3
);

  logic               btn_n;
  logic               wdt_kick;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready;
  logic [1:0]         cause;
  logic               led;

  modport master (
    input  btn_n,
    input  wdt_kick,
    output rst_out,
    output ready,
    output cause,
    output led
  );

  modport slave (
    output btn_n,
    output wdt_kick,
    input  rst_out,
    input  ready,
    input  cause,
    input  led
  );

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser plus stability counter.
// btn_dn is the accepted (debounced) pressed level of an active-low button.
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int DB_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_dn
);

  localparam int CW = clog2_min1(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counting only while the synchronised level differs from the accepted one
  // means any bounce back to the accepted level restarts the count.
  always_comb begin
    sync_d   = {sync_q[0], btn_n};
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign btn_dn = ~stable_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / push-button reset sequencer releasing NUM_OUT resets in order.
// Optional watchdog built in when RESET_SEQUENCER_WDT_EN is defined.
//
//   state    | meaning
//   POR_WAIT | all resets asserted, counting the power-on delay
//   RELEASE  | releasing one reset every STAGE_GAP clocks
//   RUN      | all resets released, ready high, led blinking
//   HOLD     | button held, all resets asserted, led on
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT    = 3,
  parameter int POR_CYCLES = 256,
  parameter int STAGE_GAP  = 16,
  parameter int DB_CYCLES  = 1024,
  parameter int WDT_CYCLES = 65536,
  parameter int BLINK_LOG2 = 22
) (
  input  logic              clk,
  input  logic              reset_n,
  reset_sequencer_if.master bus
);

  localparam int POR_W = clog2_min1(POR_CYCLES);
  localparam int GAP_W = clog2_min1(STAGE_GAP);
  localparam int CNT_W = (POR_W > GAP_W) ? POR_W : GAP_W;
  localparam int IDX_W = clog2_min1(NUM_OUT);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  logic [1:0] rsync_q, rsync_d;
  logic       rst_int_n;

  // Assertion follows reset_n immediately; release waits two clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsync_q <= 2'b00;
    end else begin
      rsync_q <= rsync_d;
    end
  end

  assign rsync_d   = {rsync_q[0], 1'b1};
  assign rst_int_n = rsync_q[1];

  logic btn_dn;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .btn_n  (bus.btn_n),
    .btn_dn (btn_dn)
  );

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_OUT-1:0]  rst_q, rst_d;
  logic                ready_q, ready_d;
  logic [1:0]          cause_q, cause_d;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;

`ifdef RESET_SEQUENCER_WDT_EN
  localparam int WDT_W = clog2_min1(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_wdt_kick;
  assign unused_wdt_kick = bus.wdt_kick;
`endif

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= POR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    blink_d = blink_q + 1'b1;
`ifdef RESET_SEQUENCER_WDT_EN
    wdt_d   = wdt_q;
`endif

    // Button outranks every in-state transition, including watchdog expiry.
    if (btn_dn && (state_q != HOLD)) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      cause_d = CAUSE_BTN;
    end else begin
      case (state_q)
        POR_WAIT: begin
          if (cnt_q == POR_LAST) begin
            cnt_d = '0;
            if (NUM_OUT == 1) begin
              rst_d   = '0;
              ready_d = 1'b1;
              state_d = RUN;
`ifdef RESET_SEQUENCER_WDT_EN
              wdt_d   = '0;
`endif
            end else begin
              rst_d[0] = 1'b0;
              idx_d    = IDX_W'(1);
              state_d  = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b0;
            idx_d        = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              ready_d = 1'b1;
              state_d = RUN;
`ifdef RESET_SEQUENCER_WDT_EN
              wdt_d   = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RUN: begin
`ifdef RESET_SEQUENCER_WDT_EN
          // A kick landing in the expiry cycle still rescues the system.
          if (bus.wdt_kick) begin
            wdt_d = '0;
          end else if (wdt_q == WDT_LAST) begin
            wdt_d   = '0;
            cnt_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            cause_d = CAUSE_WDT;
            state_d = POR_WAIT;
          end else begin
            wdt_d = wdt_q + 1'b1;
          end
`endif
        end

        HOLD: begin
          if (!btn_dn) begin
            cnt_d   = '0;
            state_d = POR_WAIT;
          end
        end

        default: begin
          state_d = POR_WAIT;
        end
      endcase
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;
  assign bus.led     = (state_q == RUN)  ? blink_q[BLINK_LOG2-1] :
                       (state_q == HOLD);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the board-level power-on reset generator used in our top levels.
- Produces NUM_OUT active-high reset outputs released in a fixed order after a programmable power-on delay.
- Adds a debounced push-button reset, an optional watchdog, a reset-cause register and a status LED.
- Sits in each board top level, between the clock source/PLL-lock signal and the CPU/peripheral reset inputs.

Parameters:
- NUM_OUT, 3, number of sequenced reset outputs (1..8); output 0 releases first.
- POR_CYCLES, 256, clocks all outputs stay asserted after entering POR_WAIT (>=2).
- STAGE_GAP, 16, clocks between release of successive outputs (>=1).
- DB_CYCLES, 1024, clocks the synchronised button must be stable before it is accepted.
- WDT_CYCLES, 65536, watchdog timeout in clocks (optional-feature builds only).
- BLINK_LOG2, 22, LED blink period is 2^BLINK_LOG2 clocks while in RUN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset (e.g. PLL lock); asserts immediately, deasserts synchronised internally.
- btn_n  in  1  raw active-low push-button, asynchronous to clk.
- wdt_kick  in  1  one-cycle strobe that restarts the watchdog (ignored without the optional feature).
- rst_out  out  NUM_OUT  active-high resets; bit i releases STAGE_GAP*i clocks after bit 0.
- ready  out  1  high only in RUN (all outputs released).
- cause  out  2  last reset source: 00 power/reset_n, 01 button, 10 watchdog.
- led  out  1  status indicator.

Behaviour:
- reset_n low: async clear; rst_out all ones, ready 0, cause 00, led 0, state POR_WAIT, counters 0. Release passes through a 2-flop synchroniser; the internal reset deasserts on the 2nd clk edge after reset_n rises.
- btn_n: 2-flop synchroniser, then debounce counter. The counter resets on any change of the synchronised level. A new level is accepted when the counter reaches DB_CYCLES-1. Output is a debounced level btn_dn.
- POR_WAIT: count 0..POR_CYCLES-1 with rst_out all ones. At the terminal count, deassert rst_out[0], clear the counter and go to RELEASE.
- RELEASE: every STAGE_GAP clocks deassert the next bit. When bit NUM_OUT-1 deasserts, go to RUN in the same cycle. With NUM_OUT=1, go straight from POR_WAIT to RUN.
- RUN: ready=1. led toggles every 2^(BLINK_LOG2-1) clocks (free-running counter bit).
- Button: btn_dn asserting in any state except HOLD sets rst_out all ones, ready 0, cause 01 and enters HOLD on the next clock.
- HOLD: led steady 1, rst_out all ones. On btn_dn deassert, go to POR_WAIT with counters cleared. A reset sequence therefore restarts fully on each press, including presses during POR_WAIT or RELEASE.
- Priority when triggers coincide: reset_n > button > watchdog.
- led: 0 in POR_WAIT and RELEASE; blink in RUN; 1 in HOLD.
- cause persists until the next trigger; only reset_n clears it.
- Counter widths are sized with $clog2 of the respective parameter.

Optional Feature:
- Macro: RESET_SEQUENCER_WDT_EN.
- Defined: a watchdog counter runs only in RUN and restarts on wdt_kick or on entering RUN. On reaching WDT_CYCLES-1 it sets rst_out all ones, cause 10 and enters POR_WAIT. A wdt_kick in the expiry cycle wins (no reset).
- Undefined: no watchdog logic; wdt_kick unused; cause never 10.

Decomposition:
- Package reset_seq_pkg: state enum (POR_WAIT, RELEASE, RUN, HOLD) and cause constants CAUSE_POR, CAUSE_BTN, CAUSE_WDT.
- One sub-module, btn_debounce: synchroniser plus DB_CYCLES stability counter, output btn_dn. Reusable for other board buttons.

Test Plan:
- Power-up, NUM_OUT=3, POR_CYCLES=256, STAGE_GAP=16, reset_n rises at t0: rst_out[0] falls 258 clocks after t0, [1] at +16, [2] at +32; ready rises with [2]; cause=00.
- Button bounce: btn_n toggles every 100 clocks for 2000 clocks with DB_CYCLES=1024 -> no trigger. Then held low 1024+2 clocks -> HOLD, rst_out=111, cause=01. On release and debounce -> full POR sequence repeats.
- Button during RELEASE after rst_out[0] released -> rst_out back to 111, sequence restarts from POR_WAIT after release.
- reset_n pulsed low mid-RUN for 1 clock -> rst_out=111 asynchronously in the same cycle; cause=00; full sequence follows.
- With RESET_SEQUENCER_WDT_EN defined and WDT_CYCLES=1000, no kicks -> 1000 clocks after RUN, cause=10 and rst_out=111. Kicks every 900 clocks -> never fires. Kick in the expiry cycle -> no reset.
- LED with BLINK_LOG2=4: led toggles every 8 clocks in RUN, is 0 in POR_WAIT and 1 in HOLD.
